// File: rtl/incr_if.sv
// Operand/result handshake bundle for incr_pipe: valid/ready on both sides
// plus the operand, step controls and the result.
interface incr_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic             cin;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, cin, mode, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, cin, mode, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/incr_pipe.sv
// Segmented pipelined incrementer/decrementer: one SEG-bit segment resolved per stage.
// Optional build macro INCR_PIPE_SATURATE_EN clamps overflow/underflow instead of wrapping.
module incr_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input logic  clk,
  input logic  rst,
  incr_if.slave io
);
  localparam int NSEG = WIDTH / SEG;

  typedef struct packed {
    logic             valid;
    logic             mode;
    logic             carry;  // carry (inc) or borrow (dec) into the next segment
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] res;
  } stage_t;

  stage_t stg_q [NSEG];
  stage_t stg_d [NSEG];
  logic   advance;

  // The whole pipe freezes while the last stage holds an unaccepted result.
  assign advance      = !stg_q[NSEG-1].valid || io.out_ready;
  assign io.in_ready  = advance;
  assign io.out_valid = stg_q[NSEG-1].valid;
  assign io.sum       = stg_q[NSEG-1].res;
  assign io.cout      = stg_q[NSEG-1].carry;

  // NOTE: every variable gets a default before the loop so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    stage_t         src;
    logic [SEG-1:0] seg;
    logic [SEG-1:0] nseg;
    logic           co;
    src  = '0;
    seg  = '0;
    nseg = '0;
    co   = 1'b0;
    for (int k = 0; k < NSEG; k++) begin
      if (k == 0) begin
        src.valid = io.in_valid;
        src.mode  = io.mode;
        src.carry = io.cin;
        src.a     = io.a;
        src.res   = io.a;
      end else begin
        src = stg_q[(k == 0) ? 0 : k - 1];
      end
      seg = src.a[k*SEG +: SEG];
      // Carry ripples only within one segment; the next segment sees it registered.
      if (src.mode) begin
        nseg = seg - SEG'(src.carry);
        co   = src.carry & ~|seg;
      end else begin
        nseg = seg + SEG'(src.carry);
        co   = src.carry & (&seg);
      end
      stg_d[k]                  = src;
      stg_d[k].res[k*SEG +: SEG] = nseg;
      stg_d[k].carry            = co;
    end
`ifdef INCR_PIPE_SATURATE_EN
    if (stg_d[NSEG-1].carry)
      stg_d[NSEG-1].res = stg_d[NSEG-1].mode ? '0 : '1;
`else
    // Wrapping build: the modulo result from the segment chain is final.
`endif
  end

  // NOTE: the payload is reset along with the valid bits so sum/cout read 0
  // during reset; upstream payload reset is cheap at this width and keeps it uniform.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSEG; k++) stg_q[k] <= '0;
    end else if (advance) begin
      // NOTE: non-blocking so every stage samples its predecessor's old value.
      for (int k = 0; k < NSEG; k++) stg_q[k] <= stg_d[k];
    end
  end
endmodule

// File: tb/tb_incr_pipe.sv
// Directed self-checking bench for incr_pipe (WIDTH=32, SEG=8, latency 4).
// Expected values are hand-computed; saturating expectations follow INCR_PIPE_SATURATE_EN.
module tb_incr_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  incr_if #(.WIDTH(32)) io ();
  incr_pipe #(.WIDTH(32), .SEG(8)) dut (.clk(clk), .rst(rst), .io(io));

  always #5 clk = ~clk;

`ifdef INCR_PIPE_SATURATE_EN
  localparam logic [31:0] OVF_SUM = 32'hFFFF_FFFF;
  localparam logic [31:0] UNF_SUM = 32'h0000_0000;
`else
  localparam logic [31:0] OVF_SUM = 32'h0000_0000;
  localparam logic [31:0] UNF_SUM = 32'hFFFF_FFFF;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+1; drives one operand and checks latency and result.
  task automatic run_one(input string tag, input logic [31:0] a, input logic cin,
                         input logic mode, input logic [31:0] exp_sum, input logic exp_cout);
    int n;
    io.in_valid = 1'b1;
    io.a        = a;
    io.cin      = cin;
    io.mode     = mode;
    @(negedge clk);
    check({tag, "_rdy"}, 64'(io.in_ready), 64'd1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      if (n == 0) io.in_valid = 1'b0;
      n++;
    end while (!io.out_valid && n < 10);
    check({tag, "_lat"}, 64'(n), 64'd4);
    check({tag, "_sum"}, 64'(io.sum), 64'(exp_sum));
    check({tag, "_cout"}, 64'(io.cout), 64'(exp_cout));
  endtask

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic        cin;
    logic        mode;
    logic [31:0] s;
    logic        c;
  } vec_t;

  vec_t vecs[14];
  vec_t strm[8];

  initial begin
    int idx, ridx, extra, stale;

    vecs[0]  = '{"inc_ff",     32'h0000_00FF, 1'b1, 1'b0, 32'h0000_0100, 1'b0};
    vecs[1]  = '{"inc_ovf",    32'hFFFF_FFFF, 1'b1, 1'b0, OVF_SUM,       1'b1};
    vecs[2]  = '{"dec_10000",  32'h0001_0000, 1'b1, 1'b1, 32'h0000_FFFF, 1'b0};
    vecs[3]  = '{"dec_unf",    32'h0000_0000, 1'b1, 1'b1, UNF_SUM,       1'b1};
    vecs[4]  = '{"pass_inc",   32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678, 1'b0};
    vecs[5]  = '{"pass_dec",   32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678, 1'b0};
    vecs[6]  = '{"inc_ffff",   32'h0000_FFFF, 1'b1, 1'b0, 32'h0001_0000, 1'b0};
    vecs[7]  = '{"inc_ffffff", 32'h00FF_FFFF, 1'b1, 1'b0, 32'h0100_0000, 1'b0};
    vecs[8]  = '{"dec_1m",     32'h0100_0000, 1'b1, 1'b1, 32'h00FF_FFFF, 1'b0};
    vecs[9]  = '{"dec_msb",    32'h8000_0000, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0};
    vecs[10] = '{"dec_ones",   32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0};
    vecs[11] = '{"inc_zero",   32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0};
    vecs[12] = '{"pass_ones",  32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[13] = '{"pass_zero",  32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b0};

    strm[0] = '{"s0", 32'h0000_00FF, 1'b1, 1'b0, 32'h0000_0100, 1'b0};
    strm[1] = '{"s1", 32'h0000_0100, 1'b1, 1'b1, 32'h0000_00FF, 1'b0};
    strm[2] = '{"s2", 32'hFFFF_FFFF, 1'b1, 1'b0, OVF_SUM,       1'b1};
    strm[3] = '{"s3", 32'h0000_0000, 1'b1, 1'b1, UNF_SUM,       1'b1};
    strm[4] = '{"s4", 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678, 1'b0};
    strm[5] = '{"s5", 32'h7FFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1'b0};
    strm[6] = '{"s6", 32'h8000_0000, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0};
    strm[7] = '{"s7", 32'h0000_FF00, 1'b1, 1'b1, 32'h0000_FEFF, 1'b0};

    io.in_valid  = 1'b0;
    io.a         = '0;
    io.cin       = 1'b0;
    io.mode      = 1'b0;
    io.out_ready = 1'b1;

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_vld", 64'(io.out_valid), 64'd0);
    check("rst_sum", 64'(io.sum), 64'd0);
    check("rst_cout", 64'(io.cout), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", 64'(io.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed single operands
    foreach (vecs[i])
      run_one(vecs[i].tag, vecs[i].a, vecs[i].cin, vecs[i].mode, vecs[i].s, vecs[i].c);
    @(posedge clk);
    #1;

    // Back-to-back stream with out_ready low in cycles 5-7
    idx   = 0;
    ridx  = 0;
    extra = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      io.out_ready = !(cyc >= 5 && cyc <= 7);
      io.in_valid  = (idx < 8);
      if (idx < 8) begin
        io.a    = strm[idx].a;
        io.cin  = strm[idx].cin;
        io.mode = strm[idx].mode;
      end
      @(negedge clk);
      if (cyc >= 5 && cyc <= 7) begin
        check("stall_rdy", 64'(io.in_ready), 64'd0);
        check("stall_vld", 64'(io.out_valid), 64'd1);
        if (ridx < 8) check("stall_sum", 64'(io.sum), 64'(strm[ridx].s));
      end
      if (io.out_valid && io.out_ready) begin
        if (ridx < 8) begin
          check({strm[ridx].tag, "_sum"}, 64'(io.sum), 64'(strm[ridx].s));
          check({strm[ridx].tag, "_cout"}, 64'(io.cout), 64'(strm[ridx].c));
          ridx++;
        end else begin
          extra++;
        end
      end
      if (io.in_valid && io.in_ready) idx++;
      @(posedge clk);
      #1;
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    check("strm_count", 64'(ridx), 64'd8);
    check("strm_extra", 64'(extra), 64'd0);

    // Reset with the first result at the output and three operands behind it
    for (int i = 0; i < 4; i++) begin
      io.in_valid = 1'b1;
      io.a        = 32'h0000_00FF + 32'(i);
      io.cin      = 1'b1;
      io.mode     = 1'(i);
      @(posedge clk);
      #1;
    end
    io.in_valid = 1'b0;
    #1;
    check("pre_rst_vld", 64'(io.out_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_vld", 64'(io.out_valid), 64'd0);
    check("async_rst_sum", 64'(io.sum), 64'd0);
    check("async_rst_cout", 64'(io.cout), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst2_rdy", 64'(io.in_ready), 64'd1);
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (io.out_valid) stale++;
    end
    check("no_stale", 64'(stale), 64'd0);
    @(posedge clk);
    #1;
    run_one("after_rst", 32'h0000_0FFF, 1'b1, 1'b0, 32'h0000_1000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
